// File: rtl/fila_controller_if.sv
// Handshake bundle between fila_controller, the deserializer/user side and the fila queue.
// The controller takes the slave modport; the driving environment takes master.
interface fila_controller_if #(
    parameter int CNT_W = 8
);
    logic             data_ready;
    logic             dequeue_req;
    logic [7:0]       len_in;
    logic             enqueue_out;
    logic             ack_out;
    logic             dequeue_out;
    logic             full_out;
    logic             empty_out;
    logic [CNT_W-1:0] drop_count;

    modport master (
        output data_ready, dequeue_req, len_in,
        input  enqueue_out, ack_out, dequeue_out, full_out, empty_out, drop_count
    );

    modport slave (
        input  data_ready, dequeue_req, len_in,
        output enqueue_out, ack_out, dequeue_out, full_out, empty_out, drop_count
    );
endinterface

// File: rtl/fila_controller.sv
// Sequences deserializer->fila enqueues, user dequeues and full-queue timeouts on clk_10KHz.
// Optional DES_SYNC_EN adds 2-flop synchronizers on data_ready and dequeue_req.
module fila_controller #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    fila_controller_if.slave  bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ENQ      = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;
    localparam logic [1:0] WAIT_LOW = 2'd3;

    localparam int              HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [7:0]      DEPTH_L   = 8'(DEPTH);

    logic rdy_s;
    logic deq_s;

`ifdef DES_SYNC_EN
    logic [1:0] rdy_sync;
    logic [1:0] deq_sync;

    always_ff @(posedge clk_10KHz or negedge reset) begin
        if (!reset) begin
            rdy_sync <= 2'b00;
            deq_sync <= 2'b00;
        end else begin
            rdy_sync <= {rdy_sync[0], bus.data_ready};
            deq_sync <= {deq_sync[0], bus.dequeue_req};
        end
    end

    assign rdy_s = rdy_sync[1];
    assign deq_s = deq_sync[1];
`else
    assign rdy_s = bus.data_ready;
    assign deq_s = bus.dequeue_req;
`endif

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_d;
    logic              rdy_q;
    logic              deq_q;
    logic              deq_pend;
    logic              pend_d;
    logic              enq_r;
    logic              ack_r;
    logic              deq_r;
    logic              full_r;
    logic              empty_r;
    logic [CNT_W-1:0]  drop_r;

    logic rise_rdy;
    logic rise_deq;
    logic full_now;
    logic guard;
    logic drop;
    logic pend_now;
    logic deq_slot;
    logic deq_issue;

    assign rise_rdy = rdy_s & ~rdy_q;
    assign rise_deq = deq_s & ~deq_q;
    assign full_now = (bus.len_in >= DEPTH_L);
    // Any queue operation this cycle blocks the next one so len_in can settle.
    assign guard    = enq_r | deq_r;

    // A byte arriving during a guard cycle parks in HOLD so it is not lost.
    always_comb begin
        state_d = state;
        hold_d  = hold_cnt;
        drop    = 1'b0;
        case (state)
            IDLE: begin
                if (rise_rdy) begin
                    if (!full_now && !guard) begin
                        state_d = ENQ;
                    end else begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end
                end
            end
            ENQ: begin
                state_d = WAIT_LOW;
            end
            HOLD: begin
                if (!full_now && !guard) begin
                    state_d = ENQ;
                end else if (full_now && hold_cnt == HOLD_LAST) begin
                    drop    = 1'b1;
                    state_d = WAIT_LOW;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_d = hold_cnt + HOLD_W'(1);
                end
            end
            WAIT_LOW: begin
                if (!rdy_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Enqueue wins the slot; a pending dequeue against an empty queue is discarded.
    assign pend_now  = deq_pend | rise_deq;
    assign deq_slot  = pend_now & ~guard & (state_d != ENQ);
    assign deq_issue = deq_slot & (bus.len_in != 8'd0);
    assign pend_d    = pend_now & ~deq_slot;

    always_ff @(posedge clk_10KHz or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rdy_q    <= 1'b1;
            deq_q    <= 1'b1;
            deq_pend <= 1'b0;
            enq_r    <= 1'b0;
            ack_r    <= 1'b0;
            deq_r    <= 1'b0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            drop_r   <= '0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_d;
            rdy_q    <= rdy_s;
            deq_q    <= deq_s;
            deq_pend <= pend_d;
            enq_r    <= (state_d == ENQ);
            ack_r    <= (state_d == ENQ) | drop;
            deq_r    <= deq_issue;
            full_r   <= (bus.len_in >= DEPTH_L);
            empty_r  <= (bus.len_in == 8'd0);
            if (drop && drop_r != {CNT_W{1'b1}}) begin
                drop_r <= drop_r + CNT_W'(1);
            end
        end
    end

    assign bus.enqueue_out = enq_r;
    assign bus.ack_out     = ack_r;
    assign bus.dequeue_out = deq_r;
    assign bus.full_out    = full_r;
    assign bus.empty_out   = empty_r;
    assign bus.drop_count  = drop_r;
endmodule

// File: tb/tb_fila_controller.sv
// Directed bench for fila_controller (default build, DES_SYNC_EN undefined).
`timescale 1us/1ns
module tb_fila_controller;
    logic clk_10KHz = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    fila_controller_if #(.CNT_W(8)) bus ();

    fila_controller #(.DEPTH(8), .HOLD_CYCLES(16), .CNT_W(8)) dut (
        .clk_10KHz(clk_10KHz),
        .reset(reset),
        .bus(bus)
    );

    always #50 clk_10KHz = ~clk_10KHz;

    task automatic step();
        @(posedge clk_10KHz);
        #1;
    endtask

    task automatic do_drop();
        bus.data_ready = 1'b0;
        step();
        step();
        bus.data_ready = 1'b1;
        repeat (18) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.data_ready = 1'b0;
        bus.dequeue_req = 1'b0;
        bus.len_in = 8'd0;
        step();
        step();
        n_checks++; if (bus.enqueue_out !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_enq: got %b expected 0", bus.enqueue_out); end
        n_checks++; if (bus.ack_out !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ack: got %b expected 0", bus.ack_out); end
        n_checks++; if (bus.dequeue_out !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_deq: got %b expected 0", bus.dequeue_out); end
        n_checks++; if (bus.full_out !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_full: got %b expected 0", bus.full_out); end
        n_checks++; if (bus.empty_out !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_empty: got %b expected 1", bus.empty_out); end
        n_checks++; if (bus.drop_count !== 8'd0) begin n_fail++; $display("[TB] FAIL rst_drop: got %0d expected 0", bus.drop_count); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_enqueue();
        bus.data_ready = 1'b1;
        step();
        n_checks++; if (bus.enqueue_out !== 1'b1) begin n_fail++; $display("[TB] FAIL t1_enq: got %b expected 1", bus.enqueue_out); end
        n_checks++; if (bus.ack_out !== 1'b1) begin n_fail++; $display("[TB] FAIL t1_ack: got %b expected 1", bus.ack_out); end
        n_checks++; if (bus.dequeue_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t1_deq: got %b expected 0", bus.dequeue_out); end
        step();
        n_checks++; if (bus.enqueue_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t1_enq_end: got %b expected 0", bus.enqueue_out); end
        n_checks++; if (bus.ack_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t1_ack_end: got %b expected 0", bus.ack_out); end
    endtask

    task automatic test_level_hold();
        int enq_cnt;
        bus.data_ready = 1'b0;
        step();
        step();
        bus.data_ready = 1'b1;
        enq_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            enq_cnt += int'(bus.enqueue_out);
        end
        n_checks++; if (enq_cnt !== 1) begin n_fail++; $display("[TB] FAIL t2_one_enq: got %0d expected 1", enq_cnt); end
        bus.data_ready = 1'b0;
        step();
        step();
        bus.data_ready = 1'b1;
        step();
        n_checks++; if (bus.enqueue_out !== 1'b1) begin n_fail++; $display("[TB] FAIL t2_second_enq: got %b expected 1", bus.enqueue_out); end
        step();
    endtask

    task automatic test_timeout_drop();
        int early;
        bus.data_ready = 1'b0;
        bus.len_in = 8'd8;
        step();
        step();
        n_checks++; if (bus.full_out !== 1'b1) begin n_fail++; $display("[TB] FAIL t3_full: got %b expected 1", bus.full_out); end
        n_checks++; if (bus.empty_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t3_empty: got %b expected 0", bus.empty_out); end
        bus.data_ready = 1'b1;
        early = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            early += int'(bus.ack_out) + int'(bus.enqueue_out);
        end
        n_checks++; if (early !== 0) begin n_fail++; $display("[TB] FAIL t3_early_pulse: got %0d expected 0", early); end
        step();
        n_checks++; if (bus.ack_out !== 1'b1) begin n_fail++; $display("[TB] FAIL t3_drop_ack: got %b expected 1", bus.ack_out); end
        n_checks++; if (bus.enqueue_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t3_drop_enq: got %b expected 0", bus.enqueue_out); end
        n_checks++; if (bus.drop_count !== 8'd1) begin n_fail++; $display("[TB] FAIL t3_drop_count: got %0d expected 1", bus.drop_count); end
        step();
        n_checks++; if (bus.ack_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t3_ack_end: got %b expected 0", bus.ack_out); end
    endtask

    task automatic test_dequeue_from_full();
        bus.data_ready = 1'b0;
        step();
        step();
        bus.data_ready = 1'b1;
        step();
        step();
        bus.dequeue_req = 1'b1;
        step();
        n_checks++; if (bus.dequeue_out !== 1'b1) begin n_fail++; $display("[TB] FAIL t4_deq: got %b expected 1", bus.dequeue_out); end
        n_checks++; if (bus.enqueue_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t4_enq_with_deq: got %b expected 0", bus.enqueue_out); end
        bus.len_in = 8'd7;
        step();
        n_checks++; if (bus.enqueue_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t4_guard_enq: got %b expected 0", bus.enqueue_out); end
        n_checks++; if (bus.dequeue_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t4_deq_end: got %b expected 0", bus.dequeue_out); end
        step();
        n_checks++; if (bus.enqueue_out !== 1'b1) begin n_fail++; $display("[TB] FAIL t4_enq: got %b expected 1", bus.enqueue_out); end
        n_checks++; if (bus.ack_out !== 1'b1) begin n_fail++; $display("[TB] FAIL t4_ack: got %b expected 1", bus.ack_out); end
        n_checks++; if (bus.drop_count !== 8'd1) begin n_fail++; $display("[TB] FAIL t4_drop_count: got %0d expected 1", bus.drop_count); end
        step();
        bus.dequeue_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.data_ready = 1'b0;
        bus.dequeue_req = 1'b0;
        bus.len_in = 8'd3;
        step();
        step();
        bus.data_ready = 1'b1;
        bus.dequeue_req = 1'b1;
        step();
        n_checks++; if (bus.enqueue_out !== 1'b1) begin n_fail++; $display("[TB] FAIL t5_enq: got %b expected 1", bus.enqueue_out); end
        n_checks++; if (bus.dequeue_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t5_deq_n1: got %b expected 0", bus.dequeue_out); end
        step();
        n_checks++; if (bus.dequeue_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t5_deq_guard: got %b expected 0", bus.dequeue_out); end
        n_checks++; if (bus.enqueue_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t5_enq_end: got %b expected 0", bus.enqueue_out); end
        step();
        n_checks++; if (bus.dequeue_out !== 1'b1) begin n_fail++; $display("[TB] FAIL t5_deq: got %b expected 1", bus.dequeue_out); end
        step();
        n_checks++; if (bus.dequeue_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t5_deq_end: got %b expected 0", bus.dequeue_out); end
        bus.dequeue_req = 1'b0;
    endtask

    task automatic test_saturation();
        bus.len_in = 8'd8;
        for (int i = 0; i < 253; i++) do_drop();
        n_checks++; if (bus.drop_count !== 8'd254) begin n_fail++; $display("[TB] FAIL sat_254: got %0d expected 254", bus.drop_count); end
        do_drop();
        n_checks++; if (bus.drop_count !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_255: got %0d expected 255", bus.drop_count); end
        do_drop();
        n_checks++; if (bus.drop_count !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_hold: got %0d expected 255", bus.drop_count); end
    endtask

    task automatic test_reset_in_hold();
        int enq_cnt;
        bus.data_ready = 1'b0;
        bus.dequeue_req = 1'b0;
        bus.len_in = 8'd8;
        step();
        step();
        bus.data_ready = 1'b1;
        step();
        step();
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (bus.enqueue_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t6_enq: got %b expected 0", bus.enqueue_out); end
        n_checks++; if (bus.ack_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t6_ack: got %b expected 0", bus.ack_out); end
        n_checks++; if (bus.full_out !== 1'b0) begin n_fail++; $display("[TB] FAIL t6_full: got %b expected 0", bus.full_out); end
        n_checks++; if (bus.empty_out !== 1'b1) begin n_fail++; $display("[TB] FAIL t6_empty: got %b expected 1", bus.empty_out); end
        n_checks++; if (bus.drop_count !== 8'd0) begin n_fail++; $display("[TB] FAIL t6_drop: got %0d expected 0", bus.drop_count); end
        step();
        step();
        bus.len_in = 8'd3;
        reset = 1'b1;
        enq_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            enq_cnt += int'(bus.enqueue_out);
        end
        n_checks++; if (enq_cnt !== 0) begin n_fail++; $display("[TB] FAIL t6_no_enq_high: got %0d expected 0", enq_cnt); end
        bus.data_ready = 1'b0;
        step();
        bus.data_ready = 1'b1;
        step();
        n_checks++; if (bus.enqueue_out !== 1'b1) begin n_fail++; $display("[TB] FAIL t6_enq_after: got %b expected 1", bus.enqueue_out); end
        n_checks++; if (bus.ack_out !== 1'b1) begin n_fail++; $display("[TB] FAIL t6_ack_after: got %b expected 1", bus.ack_out); end
        step();
    endtask

    initial begin
        $display("[TB] starting fila_controller bench");
        test_reset();
        test_single_enqueue();
        test_level_hold();
        test_timeout_drop();
        test_dequeue_from_full();
        test_back_to_back();
        test_saturation();
        test_reset_in_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
